// File: rtl/lbm_moment_sequencer.sv
// Serial D2Q9 moment engine: one shared add/sub datapath folds nine distributions into rho/jx/jy,
// with a held result register so the next node can accumulate while downstream is stalled.
module lbm_moment_sequencer #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NODE_W     = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic                  i_f_valid,
   output logic                  o_f_ready,
   input  logic [DATA_WIDTH-1:0] i_f_data,
   output logic                  o_busy,
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic [DATA_WIDTH-1:0] o_rho,
   output logic [DATA_WIDTH-1:0] o_jx,
   output logic [DATA_WIDTH-1:0] o_jy,
   output logic [NODE_W-1:0]     o_node_cnt
);

   typedef enum logic [3:0] {
      PhS0, PhS1, PhS2, PhS3, PhS4, PhS5, PhS6, PhS7, PhS8
   } phase_e;

   typedef enum logic {OutEmpty, OutFull} out_e;

   typedef enum logic [1:0] {DirZero, DirPos, DirNeg} dir_e;

   phase_e r_phase, w_phase_d;
   out_e   r_out, w_out_d;

   logic [DATA_WIDTH-1:0] r_acc_rho, r_acc_jx, r_acc_jy;
   logic [DATA_WIDTH-1:0] w_acc_rho_d, w_acc_jx_d, w_acc_jy_d;
   logic [DATA_WIDTH-1:0] r_rho, r_jx, r_jy;
   logic [DATA_WIDTH-1:0] w_rho_d, w_jx_d, w_jy_d;
   logic [DATA_WIDTH-1:0] w_sum_rho, w_sum_jx, w_sum_jy;
   logic [NODE_W-1:0]     r_node_cnt, w_node_cnt_d;

   logic w_full, w_f_ready, w_accept, w_handoff, w_last;
   dir_e w_ex_dir, w_ey_dir;

   function automatic logic [DATA_WIDTH-1:0] apply_dir(input logic [DATA_WIDTH-1:0] acc,
                                                       input logic [DATA_WIDTH-1:0] f,
                                                       input dir_e dir);
      logic [DATA_WIDTH-1:0] res;
      res = acc;
      unique case (dir)
         DirPos:  res = acc + f;
         DirNeg:  res = acc - f;
         default: res = acc;
      endcase
      return res;
   endfunction

   // Lattice direction table: ex = {0,1,0,-1,0,1,-1,-1,1}, ey = {0,0,1,0,-1,1,1,-1,-1}.
   always_comb begin
      w_ex_dir = DirZero;
      w_ey_dir = DirZero;
      unique case (r_phase)
         PhS1:    begin w_ex_dir = DirPos;  w_ey_dir = DirZero; end
         PhS2:    begin w_ex_dir = DirZero; w_ey_dir = DirPos;  end
         PhS3:    begin w_ex_dir = DirNeg;  w_ey_dir = DirZero; end
         PhS4:    begin w_ex_dir = DirZero; w_ey_dir = DirNeg;  end
         PhS5:    begin w_ex_dir = DirPos;  w_ey_dir = DirPos;  end
         PhS6:    begin w_ex_dir = DirNeg;  w_ey_dir = DirPos;  end
         PhS7:    begin w_ex_dir = DirNeg;  w_ey_dir = DirNeg;  end
         PhS8:    begin w_ex_dir = DirPos;  w_ey_dir = DirNeg;  end
         default: begin w_ex_dir = DirZero; w_ey_dir = DirZero; end
      endcase
   end

   assign w_full    = (r_out == OutFull);
   // The final beat can only stall when the held result has nowhere to go.
   assign w_f_ready = !i_rst && !i_flush && !((r_phase == PhS8) && w_full && !i_m_ready);
   assign w_accept  = i_f_valid && w_f_ready;
   assign w_handoff = w_full && i_m_ready;
   assign w_last    = w_accept && (r_phase == PhS8);

   assign w_sum_rho = r_acc_rho + i_f_data;
   assign w_sum_jx  = apply_dir(r_acc_jx, i_f_data, w_ex_dir);
   assign w_sum_jy  = apply_dir(r_acc_jy, i_f_data, w_ey_dir);

   always_comb begin
      w_phase_d = r_phase;
      if (i_flush) begin
         w_phase_d = PhS0;
      end else if (w_accept) begin
         if (r_phase == PhS8) begin
            w_phase_d = PhS0;
         end else begin
            w_phase_d = phase_e'(r_phase + 4'd1);
         end
      end
   end

   always_comb begin
      w_out_d = r_out;
      unique case (r_out)
         OutEmpty: if (w_last) w_out_d = OutFull;
         OutFull: begin
            if (w_last) begin
               w_out_d = OutFull;
            end else if (i_m_ready) begin
               w_out_d = OutEmpty;
            end
         end
         default: w_out_d = OutEmpty;
      endcase
   end

   always_comb begin
      w_acc_rho_d  = r_acc_rho;
      w_acc_jx_d   = r_acc_jx;
      w_acc_jy_d   = r_acc_jy;
      w_rho_d      = r_rho;
      w_jx_d       = r_jx;
      w_jy_d       = r_jy;
      w_node_cnt_d = r_node_cnt;
      if (w_accept) begin
         // S0 loads rather than adds, so no explicit clear is needed between nodes.
         if (r_phase == PhS0) begin
            w_acc_rho_d = i_f_data;
            w_acc_jx_d  = '0;
            w_acc_jy_d  = '0;
         end else begin
            w_acc_rho_d = w_sum_rho;
            w_acc_jx_d  = w_sum_jx;
            w_acc_jy_d  = w_sum_jy;
         end
      end
      if (w_last) begin
         w_rho_d = w_sum_rho;
         w_jx_d  = w_sum_jx;
         w_jy_d  = w_sum_jy;
      end
      if (w_handoff) begin
         w_node_cnt_d = r_node_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase <= PhS0;
         r_out   <= OutEmpty;
      end else begin
         r_phase <= w_phase_d;
         r_out   <= w_out_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc_rho  <= '0;
         r_acc_jx   <= '0;
         r_acc_jy   <= '0;
         r_rho      <= '0;
         r_jx       <= '0;
         r_jy       <= '0;
         r_node_cnt <= '0;
      end else begin
         r_acc_rho  <= w_acc_rho_d;
         r_acc_jx   <= w_acc_jx_d;
         r_acc_jy   <= w_acc_jy_d;
         r_rho      <= w_rho_d;
         r_jx       <= w_jx_d;
         r_jy       <= w_jy_d;
         r_node_cnt <= w_node_cnt_d;
      end
   end

   assign o_f_ready  = w_f_ready;
   assign o_busy     = (r_phase != PhS0);
   assign o_m_valid  = w_full;
   assign o_rho      = r_rho;
   assign o_jx       = r_jx;
   assign o_jy       = r_jy;
   assign o_node_cnt = r_node_cnt;

endmodule

// File: tb/tb_lbm_moment_sequencer.sv
// Bench for lbm_moment_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model that buffers the nine beats of a node and sums them with the direction table.
module tb_lbm_moment_sequencer;

   localparam int DW = 64;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst, flush, f_valid, m_ready;
   logic [DW-1:0] f_data;
   logic          f_ready, busy, m_valid;
   logic [DW-1:0] rho, jx, jy;
   logic [NW-1:0] node_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lbm_moment_sequencer #(.DATA_WIDTH(DW), .NODE_W(NW)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_flush    (flush),
      .i_f_valid  (f_valid),
      .o_f_ready  (f_ready),
      .i_f_data   (f_data),
      .o_busy     (busy),
      .o_m_valid  (m_valid),
      .i_m_ready  (m_ready),
      .o_rho      (rho),
      .o_jx       (jx),
      .o_jy       (jy),
      .o_node_cnt (node_cnt)
   );

   // Reference model: beat position, captured beats, held result and handoff count.
   int            md_idx = 0;
   logic [DW-1:0] md_f[9];
   bit            md_full = 0;
   logic [DW-1:0] md_rho = '0, md_jx = '0, md_jy = '0;
   logic [NW-1:0] md_cnt = '0;
   int            ex_t[9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
   int            ey_t[9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

   function automatic bit md_ready();
      return !rst && !flush && !(md_idx == 8 && md_full && !m_ready);
   endfunction

   task automatic md_moments();
      logic [DW-1:0] r, x, y;
      r = '0; x = '0; y = '0;
      for (int i = 0; i < 9; i++) begin
         r = r + md_f[i];
         if (ex_t[i] > 0) x = x + md_f[i]; else if (ex_t[i] < 0) x = x - md_f[i];
         if (ey_t[i] > 0) y = y + md_f[i]; else if (ey_t[i] < 0) y = y - md_f[i];
      end
      md_rho = r; md_jx = x; md_jy = y;
   endtask

   // Advance model with the inputs currently driven, then one clock; returns at the negedge.
   task automatic tick();
      bit acc, ho;
      acc = f_valid && md_ready();
      ho  = md_full && m_ready;
      if (rst) begin
         md_idx = 0; md_full = 0; md_rho = '0; md_jx = '0; md_jy = '0; md_cnt = '0;
      end else begin
         if (ho) begin md_full = 0; md_cnt = md_cnt + 1'b1; end
         if (flush) begin
            md_idx = 0;
         end else if (acc) begin
            md_f[md_idx] = f_data;
            if (md_idx == 8) begin md_moments(); md_full = 1; md_idx = 0; end
            else md_idx++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1; flush = 0; f_valid = 1; m_ready = 0; f_data = 64'h0100_0000_0000_0000;
      tick(); tick();
      #1;
      n_checks++; if (f_ready !== 1'b0) begin n_errors++; $display("FAIL reset_f_ready: got %b want 0", f_ready); end
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (node_cnt !== '0) begin n_errors++; $display("FAIL reset_node_cnt: got %0d want 0", node_cnt); end
      n_checks++; if ({rho, jx, jy} !== '0) begin n_errors++; $display("FAIL reset_moments: got %h %h %h want 0", rho, jx, jy); end
      rst = 0; f_valid = 0;
      tick();
   endtask

   task automatic test_ramp();
      logic [NW-1:0] c0;
      c0 = md_cnt;
      m_ready = 1;
      for (int i = 0; i < 9; i++) begin
         f_valid = 1; f_data = 64'(i + 1) << 56;
         #1;
         n_checks++; if (f_ready !== 1'b1) begin n_errors++; $display("FAIL ramp_f_ready beat %0d: got %b want 1", i, f_ready); end
         tick();
      end
      f_valid = 0;
      n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL ramp_m_valid: got %b want 1", m_valid); end
      n_checks++; if (rho !== 64'h2D00_0000_0000_0000) begin n_errors++; $display("FAIL ramp_rho: got %h want 2d00000000000000", rho); end
      n_checks++; if (jx !== 64'hFE00_0000_0000_0000) begin n_errors++; $display("FAIL ramp_jx: got %h want fe00000000000000", jx); end
      n_checks++; if (jy !== 64'hFA00_0000_0000_0000) begin n_errors++; $display("FAIL ramp_jy: got %h want fa00000000000000", jy); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ramp_busy: got %b want 0", busy); end
      tick();
      n_checks++; if (node_cnt !== c0 + 1'b1) begin n_errors++; $display("FAIL ramp_node_cnt: got %0d want %0d", node_cnt, c0 + 1'b1); end
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL ramp_drain: got %b want 0", m_valid); end
   endtask

   task automatic test_wrap();
      m_ready = 0;
      for (int i = 0; i < 9; i++) begin
         f_valid = 1;
         f_data = (i == 0) ? 64'h7F00_0000_0000_0000 : (i == 1) ? 64'h0200_0000_0000_0000 : '0;
         tick();
      end
      f_valid = 0;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_hold_valid: got %b want 1", m_valid); end
         n_checks++; if (rho !== 64'h8100_0000_0000_0000) begin n_errors++; $display("FAIL wrap_rho: got %h want 8100000000000000", rho); end
         n_checks++; if (jx !== 64'h0200_0000_0000_0000) begin n_errors++; $display("FAIL wrap_jx: got %h want 0200000000000000", jx); end
         n_checks++; if (jy !== '0) begin n_errors++; $display("FAIL wrap_jy: got %h want 0", jy); end
         tick();
      end
      m_ready = 1;
      tick();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] a_rho;
      logic [NW-1:0] c0;
      m_ready = 0;
      for (int i = 0; i < 9; i++) begin f_valid = 1; f_data = {$urandom, $urandom}; tick(); end
      a_rho = md_rho;
      c0 = md_cnt;
      n_checks++; if (rho !== a_rho) begin n_errors++; $display("FAIL bp_a_rho: got %h want %h", rho, a_rho); end
      for (int i = 0; i < 8; i++) begin
         f_valid = 1; f_data = {$urandom, $urandom};
         #1;
         n_checks++; if (f_ready !== 1'b1) begin n_errors++; $display("FAIL bp_b_ready beat %0d: got %b want 1", i, f_ready); end
         tick();
      end
      f_valid = 1; f_data = {$urandom, $urandom};
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++; if (f_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall: got %b want 0", f_ready); end
         tick();
      end
      n_checks++; if (rho !== a_rho) begin n_errors++; $display("FAIL bp_hold_rho: got %h want %h", rho, a_rho); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL bp_busy: got %b want 1", busy); end
      m_ready = 1;
      #1;
      n_checks++; if (f_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release: got %b want 1", f_ready); end
      tick();
      f_valid = 0;
      n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL bp_b_valid: got %b want 1", m_valid); end
      n_checks++; if ({rho, jx, jy} !== {md_rho, md_jx, md_jy}) begin n_errors++; $display("FAIL bp_b_moments: got %h %h %h want %h %h %h", rho, jx, jy, md_rho, md_jx, md_jy); end
      n_checks++; if (node_cnt !== c0 + 1'b1) begin n_errors++; $display("FAIL bp_node_cnt: got %0d want %0d", node_cnt, c0 + 1'b1); end
      tick();
   endtask

   task automatic test_flush();
      m_ready = 1;
      for (int i = 0; i < 4; i++) begin f_valid = 1; f_data = {$urandom, $urandom}; tick(); end
      flush = 1;
      #1;
      n_checks++; if (f_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", f_ready); end
      tick();
      flush = 0;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL flush_busy: got %b want 0", busy); end
      for (int i = 0; i < 9; i++) begin f_valid = 1; f_data = 64'h0100_0000_0000_0000; tick(); end
      f_valid = 0;
      n_checks++; if (rho !== 64'h0900_0000_0000_0000) begin n_errors++; $display("FAIL flush_rho: got %h want 0900000000000000", rho); end
      n_checks++; if ({jx, jy} !== '0) begin n_errors++; $display("FAIL flush_jxjy: got %h %h want 0 0", jx, jy); end
      tick();
   endtask

   task automatic test_reset_mid();
      m_ready = 0;
      for (int i = 0; i < 14; i++) begin f_valid = 1; f_data = {$urandom, $urandom}; tick(); end
      rst = 1; f_valid = 0;
      tick();
      rst = 0;
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
      n_checks++; if (node_cnt !== '0) begin n_errors++; $display("FAIL rstmid_cnt: got %0d want 0", node_cnt); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      m_ready = 1;
      for (int i = 0; i < 9; i++) begin f_valid = 1; f_data = {$urandom, $urandom}; tick(); end
      f_valid = 0;
      n_checks++; if ({rho, jx, jy} !== {md_rho, md_jx, md_jy}) begin n_errors++; $display("FAIL rstmid_moments: got %h %h %h want %h %h %h", rho, jx, jy, md_rho, md_jx, md_jy); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [NW-1:0] c0;
      int pulses;
      c0 = md_cnt; pulses = 0;
      m_ready = 1;
      for (int k = 1; k <= 27; k++) begin
         f_valid = 1; f_data = {$urandom, $urandom};
         #1;
         n_checks++; if (f_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready cycle %0d: got %b want 1", k, f_ready); end
         tick();
         if (m_valid) pulses++;
         n_checks++; if (m_valid !== (k % 9 == 0)) begin n_errors++; $display("FAIL b2b_valid cycle %0d: got %b want %b", k, m_valid, k % 9 == 0); end
         if (k % 9 == 0) begin
            n_checks++; if ({rho, jx, jy} !== {md_rho, md_jx, md_jy}) begin n_errors++; $display("FAIL b2b_moments cycle %0d: got %h %h %h want %h %h %h", k, rho, jx, jy, md_rho, md_jx, md_jy); end
         end
      end
      f_valid = 0;
      tick();
      n_checks++; if (pulses !== 3) begin n_errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
      n_checks++; if (node_cnt !== c0 + 2'd3) begin n_errors++; $display("FAIL b2b_node_cnt: got %0d want %0d", node_cnt, c0 + 2'd3); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         f_valid = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         flush   = ($urandom_range(0, 15) == 0);
         rst     = ($urandom_range(0, 99) == 0);
         f_data  = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255)) << 56;
         #1;
         n_checks++; if (f_ready !== md_ready()) begin n_errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", k, f_ready, md_ready()); end
         tick();
         n_checks++; if (m_valid !== md_full) begin n_errors++; $display("FAIL rand_valid cycle %0d: got %b want %b", k, m_valid, md_full); end
         n_checks++; if (busy !== (md_idx != 0)) begin n_errors++; $display("FAIL rand_busy cycle %0d: got %b want %b", k, busy, md_idx != 0); end
         n_checks++; if (node_cnt !== md_cnt) begin n_errors++; $display("FAIL rand_node_cnt cycle %0d: got %0d want %0d", k, node_cnt, md_cnt); end
         if (md_full) begin
            n_checks++; if ({rho, jx, jy} !== {md_rho, md_jx, md_jy}) begin n_errors++; $display("FAIL rand_moments cycle %0d: got %h %h %h want %h %h %h", k, rho, jx, jy, md_rho, md_jx, md_jy); end
         end
      end
      rst = 0; flush = 0; f_valid = 0; m_ready = 1;
      tick();
   endtask

   initial begin
      rst = 1; flush = 0; f_valid = 0; m_ready = 0; f_data = '0;
      @(negedge clk);
      test_reset();
      test_ramp();
      test_wrap();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
